shifter_seq: RTL and testbench



---
 rtl/shifter_seq.sv | 96 +++++++++
 tb/tb_shifter_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// Multi-cycle 32-bit shifter: SRL/SRA/SLL/pass-through, one bit position per clock,
// under a start/busy/done handshake. Op encoding matches the combinational shifter.
module shifter_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [1:0]  shiftop,
    input  logic [4:0]  shiftamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] work, work_next;
    logic [31:0] shifted;
    logic [1:0]  op, op_next;
    logic [4:0]  count, count_next;
    logic [31:0] result_next;

    // One-bit step of the captured operation
    always_comb begin
        shifted = work;
        case (op)
            2'b00:   shifted = {1'b0, work[31:1]};
            2'b01:   shifted = {work[31], work[31:1]};
            2'b10:   shifted = {work[30:0], 1'b0};
            default: shifted = work;
        endcase
    end

    always_comb begin
        state_next  = state;
        work_next   = work;
        op_next     = op;
        count_next  = count;
        result_next = result;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    work_next  = in;
                    op_next    = shiftop;
                    count_next = shiftamt;
                    if (shiftamt != '0 && shiftop != 2'b11) begin
                        state_next = SHIFT;
                    end else begin
                        state_next  = DONE;
                        result_next = in;
                    end
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                work_next  = shifted;
                count_next = count - 5'd1;
                // result is loaded only on the edge entering DONE
                if (count == 5'd1) begin
                    state_next  = DONE;
                    result_next = shifted;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            work   <= '0;
            op     <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            state  <= state_next;
            work   <= work_next;
            op     <= op_next;
            count  <= count_next;
            result <= result_next;
        end
    end

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq: directed cases plus random requests
// compared against an arithmetic reference model (shift operators, latency formula).
module tb_shifter_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] din;
    logic [1:0]  shiftop;
    logic [4:0]  shiftamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_prev;

    shifter_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in       (din),
        .shiftop  (shiftop),
        .shiftamt (shiftamt),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] d, input logic [1:0] op,
                                               input logic [4:0] amt);
        case (op)
            2'b00:   return d >> amt;
            2'b01:   return $unsigned($signed(d) >>> amt);
            2'b10:   return d << amt;
            default: return d;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [4:0] amt);
        if (amt == 5'd0 || op == 2'b11) return 1;
        return int'(amt) + 1;
    endfunction

    // Called at posedge+1; returns at posedge+1 one cycle after the done pulse.
    task automatic run_txn(input logic [31:0] d, input logic [1:0] op, input logic [4:0] amt,
                           input bit hammer);
        logic [31:0] exp;
        int          lat;
        int          n;
        exp = ref_result(d, op, amt);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("idle_before_start", {31'd0, busy}, 32'd0);
        start = 1'b1; din = d; shiftop = op; shiftamt = amt;
        @(posedge clk); #1;
        if (!hammer) start = 1'b0;
        din = $urandom; shiftop = 2'($urandom); shiftamt = 5'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            check("result_held_in_shift", result, exp_prev);
            check("busy_in_shift", {31'd0, busy}, 32'd1);
            if (hammer) start = 1'b1;
            din = $urandom; shiftop = 2'($urandom); shiftamt = 5'($urandom);
            @(posedge clk); #1; lat++;
        end
        start = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", lat, ref_latency(op, amt));
        check("result", result, exp);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        exp_prev = exp;
        @(posedge clk); #1;
        check("done_single_pulse", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("result_hold", result, exp);
        if (hammer) begin
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                check("no_extra_done", {31'd0, done}, 32'd0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; din = '0; shiftop = '0; shiftamt = '0;
        exp_prev = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(32'h0000_0001, 2'b00, 5'd1, 1'b0);
        run_txn(32'h0000_0001, 2'b00, 5'd2, 1'b0);
        run_txn(32'h0000_0001, 2'b00, 5'd3, 1'b0);
        run_txn(32'h8000_0000, 2'b01, 5'd3, 1'b0);
        check("sra_const", exp_prev, 32'hF000_0000);
        run_txn(32'h8000_0000, 2'b00, 5'd3, 1'b0);
        check("srl_const", exp_prev, 32'h1000_0000);
        run_txn(32'h0000_0001, 2'b10, 5'd3, 1'b0);
        check("sll3_const", exp_prev, 32'h0000_0008);
        run_txn(32'h0000_0001, 2'b10, 5'd31, 1'b0);
        check("sll31_const", exp_prev, 32'h8000_0000);
        run_txn(32'hDEAD_BEEF, 2'b10, 5'd0, 1'b0);
        run_txn(32'hDEAD_BEEF, 2'b11, 5'd7, 1'b0);
        run_txn(32'h0000_0001, 2'b10, 5'd5, 1'b1);
        check("hammer_const", exp_prev, 32'h0000_0020);

        // Abort a 10-bit shift with reset part-way through
        run_txn(32'h1234_5678, 2'b01, 5'd4, 1'b0);
        start = 1'b1; din = 32'h0000_0003; shiftop = 2'b10; shiftamt = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_prev = 32'h0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_txn(32'h0000_0003, 2'b10, 5'd10, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            run_txn($urandom, 2'($urandom), a, 1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
